// File: rtl/inject_scheduler_pkg.sv
// Shared flit definitions for the NoC: the Router, ProcessorElement and
// inject_scheduler blocks all use this package.
//   FlitW                 : flit width in bits
//   FlitTypeHi/FlitTypeLo : position of the 2-bit flit-type field
//   flit_type_e           : head / body / tail / single encodings
package inject_scheduler_pkg;

  localparam int unsigned FlitW      = 20;
  localparam int unsigned FlitTypeHi = 19;
  localparam int unsigned FlitTypeLo = 18;

  typedef enum logic [1:0] {
    FlitBody   = 2'b00,
    FlitTail   = 2'b01,
    FlitHead   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

  // Head and single flits open a packet; tail and single flits close one.
  function automatic logic is_start(input logic [1:0] ty);
    return ty[1];
  endfunction

  function automatic logic is_end(input logic [1:0] ty);
    return ty[0];
  endfunction

endpackage

// File: rtl/inject_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// the pointer, ascending with wrap-around.
//   req_i       : request vector
//   ptr_i       : highest-priority index
//   gnt_o       : one-hot grant
//   gnt_idx_o   : binary index of the grant
//   gnt_valid_o : some request was granted
module inject_scheduler_rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  always_comb begin
    logic [PtrW-1:0] idx;
    logic            found;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    found       = 1'b0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = PtrW'((32'(ptr_i) + off) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_idx_o  = idx;
        gnt_o[idx] = 1'b1;
      end
    end
    gnt_valid_o = found;
  end

endmodule

// File: rtl/inject_scheduler.sv
// Credit-based scheduler merging NREQ PE flit sources onto one router inject
// port. A packet locks the port from head to tail; new packets are picked
// round-robin.
//   clk, RST      : clock, synchronous active-high reset
//   req_flit      : NREQ packed 20-bit flits, source i at [20*i+19:20*i]
//   req_valid     : per-source flit valid
//   req_ready     : per-source flit consumed (combinational)
//   dataout       : registered flit to the router
//   out_valid     : dataout valid this cycle
//   ci            : credit-return pulse from the router
// Optional (macro INJECT_SCHED_STATS_EN): sent_count, stall_count outputs.
module inject_scheduler
  import inject_scheduler_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned CREDIT_MAX = 4
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [NREQ*FlitW-1:0] req_flit,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  output logic [FlitW-1:0]     dataout,
  output logic                 out_valid,
  input  logic                 ci
`ifdef INJECT_SCHED_STATS_EN
  ,
  output logic [15:0]          sent_count,
  output logic [15:0]          stall_count
`endif
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(CREDIT_MAX + 1);
  localparam logic [CntW-1:0] CreditFull = CntW'(CREDIT_MAX);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [PtrW-1:0]  owner_q, owner_d;
  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  credit_q, credit_d;
  logic [FlitW-1:0] dataout_q, dataout_d;
  logic             out_valid_q, out_valid_d;

  logic [NREQ-1:0]  start_req;
  logic [NREQ-1:0]  arb_gnt;
  logic [PtrW-1:0]  arb_idx;
  logic             arb_valid;
  logic [PtrW-1:0]  sel_idx;
  logic [FlitW-1:0] sel_flit;
  logic             elig_valid;
  logic             credit_ok;
  logic             send;

  // Only packet-opening flits compete in IDLE; stray body/tail flits stall.
  always_comb begin
    start_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      start_req[i] = req_valid[i] && is_start(req_flit[FlitW*i+FlitTypeLo +: 2]);
    end
  end

  inject_scheduler_rr_arbiter #(
    .NREQ(NREQ),
    .PtrW(PtrW)
  ) u_rr_arbiter (
    .req_i      (start_req),
    .ptr_i      (rr_ptr_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx),
    .gnt_valid_o(arb_valid)
  );

  always_comb begin
    sel_idx    = (state_q == StLocked) ? owner_q : arb_idx;
    sel_flit   = req_flit[FlitW*sel_idx +: FlitW];
    elig_valid = (state_q == StLocked) ? req_valid[sel_idx] : arb_valid;
    credit_ok  = (credit_q != '0);
    send       = elig_valid && credit_ok && !RST;
    req_ready  = '0;
    if (send) begin
      if (state_q == StLocked) begin
        req_ready[sel_idx] = 1'b1;
      end else begin
        req_ready = arb_gnt;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    credit_d    = credit_q;
    dataout_d   = dataout_q;
    out_valid_d = send;
    if (send) begin
      dataout_d = sel_flit;
      owner_d   = sel_idx;
      if (is_end(sel_flit[FlitTypeHi:FlitTypeLo])) begin
        state_d  = StIdle;
        rr_ptr_d = (sel_idx == PtrW'(NREQ - 1)) ? '0 : sel_idx + PtrW'(1);
      end else begin
        state_d = StLocked;
      end
    end
    case ({send, ci})
      2'b10:   credit_d = credit_q - CntW'(1);
      2'b01:   if (credit_q != CreditFull) credit_d = credit_q + CntW'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      credit_q    <= CreditFull;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      credit_q    <= credit_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign dataout   = dataout_q;
  assign out_valid = out_valid_q;

`ifdef INJECT_SCHED_STATS_EN
  logic [15:0] sent_q, sent_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    sent_d  = send ? sent_q + 16'd1 : sent_q;
    stall_d = (elig_valid && !credit_ok) ? stall_q + 16'd1 : stall_q;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      sent_q  <= sent_d;
      stall_q <= stall_d;
    end
  end

  assign sent_count  = sent_q;
  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_inject_scheduler.sv
// Self-checking bench for inject_scheduler: expected flits are queued when a
// send is expected and compared when out_valid appears.
module tb_inject_scheduler;
  import inject_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic [79:0] req_flit;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [19:0] dataout;
  logic        out_valid;
  logic        ci;
`ifdef INJECT_SCHED_STATS_EN
  logic [15:0] sent_count;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  inject_scheduler #(
    .NREQ      (4),
    .CREDIT_MAX(4)
  ) dut (
    .clk        (clk),
    .RST        (RST),
    .req_flit   (req_flit),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .ci         (ci)
`ifdef INJECT_SCHED_STATS_EN
    ,
    .sent_count (sent_count),
    .stall_count(stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [1:0] ty, input int src, input int pl);
    return {ty, 6'(src), 12'(pl)};
  endfunction

  // Output monitor: every out_valid must match the oldest expected flit.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
      else check("dataout", {12'd0, dataout}, {12'd0, exp_q.pop_front()});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [19:0] f);
    req_flit[20*s +: 20] = f;
  endtask

  // Check combinational ready for the driven inputs, queue the expected
  // flit if a send is expected, then advance one clock.
  task automatic step(input string tag, input logic [3:0] exp_rdy, input logic [19:0] f);
    #1;
    check(tag, {28'd0, req_ready}, {28'd0, exp_rdy});
    if (exp_rdy != 4'd0) exp_q.push_back(f);
    cyc();
  endtask

  task automatic do_reset();
    RST       = 1'b1;
    req_valid = 4'd0;
    ci        = 1'b0;
    cyc();
    cyc();
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b1;
    ci        = 1'b0;
    req_flit  = '0;
    for (int s = 0; s < 4; s++) set_src(s, mk(2'b11, s, 'h100 + s));
    req_valid = 4'hF;
    #1;
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    cyc();
    cyc();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_dataout", {12'd0, dataout}, 32'd0);
    check("rst_credit", 32'(dut.credit_q), 32'd4);
    check("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    RST       = 1'b0;
    req_valid = 4'd0;
    cyc();

    // Credit sequence: four back-to-back singles, starve, one ci, one send.
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      set_src(0, mk(2'b11, 0, k));
      step("s1_send", 4'b0001, mk(2'b11, 0, k));
    end
    set_src(0, mk(2'b11, 0, 4));
    ci = 1'b1;
    step("s1_starved", 4'b0000, '0);
    ci = 1'b0;
    step("s1_ci_send", 4'b0001, mk(2'b11, 0, 4));
    req_valid = 4'd0;
    check("s1_credit_zero", 32'(dut.credit_q), 32'd0);
    ci = 1'b1;
    for (int k = 0; k < 4; k++) step("s1_refill", 4'b0000, '0);
    check("s1_credit_full", 32'(dut.credit_q), 32'd4);
    step("s1_sat", 4'b0000, '0);
    check("s1_credit_sat", 32'(dut.credit_q), 32'd4);
    ci = 1'b0;
    check("s1_dataout_hold", {12'd0, dataout}, {12'd0, mk(2'b11, 0, 4)});
    check("s1_out_valid_low", {31'd0, out_valid}, 32'd0);

    // Packet lock: source 1 H/B/T while source 2 waits with a single.
    req_valid = 4'b0110;
    set_src(2, mk(2'b11, 2, 'h22));
    set_src(1, mk(2'b10, 1, 'h1));
    step("s2_head", 4'b0010, mk(2'b10, 1, 'h1));
    set_src(1, mk(2'b00, 1, 'h2));
    step("s2_body", 4'b0010, mk(2'b00, 1, 'h2));
    set_src(1, mk(2'b01, 1, 'h3));
    step("s2_tail", 4'b0010, mk(2'b01, 1, 'h3));
    req_valid = 4'b0100;
    step("s2_src2", 4'b0100, mk(2'b11, 2, 'h22));
    req_valid = 4'd0;
    ci = 1'b1;
    for (int k = 0; k < 4; k++) step("s2_refill", 4'b0000, '0);
    ci = 1'b0;

    // Round-robin fairness from rr_ptr=0 with credits replenished.
    do_reset();
    for (int s = 0; s < 4; s++) set_src(s, mk(2'b11, s, 'h30 + s));
    req_valid = 4'hF;
    ci        = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << (k % 4);
      step("s3_rr", oh, mk(2'b11, k % 4, 'h30 + (k % 4)));
    end
    ci        = 1'b0;
    req_valid = 4'd0;
    check("s3_credit", 32'(dut.credit_q), 32'd4);

    // Simultaneous send and ci at credit 2; ci at full.
    req_valid = 4'b0001;
    set_src(0, mk(2'b11, 0, 'h40));
    step("s4_send", 4'b0001, mk(2'b11, 0, 'h40));
    step("s4_send", 4'b0001, mk(2'b11, 0, 'h40));
    check("s4_credit2", 32'(dut.credit_q), 32'd2);
    ci = 1'b1;
    step("s4_simul", 4'b0001, mk(2'b11, 0, 'h40));
    check("s4_credit_simul", 32'(dut.credit_q), 32'd2);
    req_valid = 4'd0;
    step("s4_ci", 4'b0000, '0);
    step("s4_ci", 4'b0000, '0);
    step("s4_ci_full", 4'b0000, '0);
    check("s4_credit_full", 32'(dut.credit_q), 32'd4);
    ci = 1'b0;

    // Reset mid-packet after H and B; the stray tail must not be granted.
    req_valid = 4'b0010;
    set_src(1, mk(2'b10, 1, 'h51));
    step("s5_head", 4'b0010, mk(2'b10, 1, 'h51));
    set_src(1, mk(2'b00, 1, 'h52));
    step("s5_body", 4'b0010, mk(2'b00, 1, 'h52));
    set_src(1, mk(2'b01, 1, 'h53));
    RST = 1'b1;
    step("s5_rst_ready", 4'b0000, '0);
    RST = 1'b0;
    check("s5_state", 32'(dut.state_q), 32'd0);
    check("s5_credit", 32'(dut.credit_q), 32'd4);
    check("s5_out_valid", {31'd0, out_valid}, 32'd0);
    check("s5_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
    step("s5_stray", 4'b0000, '0);
    step("s5_stray", 4'b0000, '0);
    req_valid = 4'd0;

`ifdef INJECT_SCHED_STATS_EN
    // Five sends and three credit-starved cycles.
    do_reset();
    req_valid = 4'b0001;
    set_src(0, mk(2'b11, 0, 'h60));
    for (int k = 0; k < 4; k++) step("st_send", 4'b0001, mk(2'b11, 0, 'h60));
    step("st_stall", 4'b0000, '0);
    step("st_stall", 4'b0000, '0);
    ci = 1'b1;
    step("st_stall", 4'b0000, '0);
    ci = 1'b0;
    step("st_send", 4'b0001, mk(2'b11, 0, 'h60));
    req_valid = 4'd0;
    check("st_sent", {16'd0, sent_count}, 32'd5);
    check("st_stall", {16'd0, stall_count}, 32'd3);
`endif

    cyc();
    cyc();
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
